move_tx_buffer: RTL and testbench

Output buffer between the move-generation top level and the CPU. It captures the 32-bit move words the top level emits during a search (write strobe + data) into a 256-entry frame buffer. On the end-of-search strobe it freezes the frame, publishes its length and holds a level interrupt to the CPU. It then serves CPU reads in order until the CPU acknowledges, which releases the buffer for the next search.

---
 rtl/zezima_pkg.sv | 24 ++
 rtl/move_tx_buffer_if.sv | 30 +++
 rtl/tx_ram.sv | 26 ++
 rtl/move_tx_buffer.sv | 89 ++++++++
 tb/tb_move_tx_buffer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/zezima_pkg.sv
// Shared move-generation definitions: word geometry, move field layout and
// the tx buffer state encoding.
package zezima_pkg;

  localparam int MOVE_DW    = 32;
  localparam int MOVE_DEPTH = 256;
  localparam int MOVE_AW    = $clog2(MOVE_DEPTH);

  typedef enum logic {
    FILL_ST  = 1'b0,
    READY_ST = 1'b1
  } tx_state_t;

  typedef struct packed {
    logic [3:0] flags;
    logic [5:0] to;
    logic [5:0] from;
  } move_t;

  function automatic move_t move_of(input logic [MOVE_DW-1:0] word);
    return move_t'(word[15:0]);
  endfunction

endpackage

// File: rtl/move_tx_buffer_if.sv
// Move-word producer / CPU side bundle of the tx buffer; master drives the
// strobes, slave is the buffer.
interface move_tx_buffer_if
  import zezima_pkg::*;
#(
  parameter int DW = MOVE_DW,
  parameter int AW = MOVE_AW
);
  logic          in_wr;
  logic [DW-1:0] in_wdata;
  logic          frame_done;
  logic          cpu_rd;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rdata_dav;
  logic          cpu_irq;
  logic [AW:0]   frame_len;
  logic          overflow;
  logic          underrun;

  modport master (
    output in_wr, in_wdata, frame_done, cpu_rd, cpu_ack,
    input  cpu_rdata, cpu_rdata_dav, cpu_irq, frame_len, overflow, underrun
  );

  modport slave (
    input  in_wr, in_wdata, frame_done, cpu_rd, cpu_ack,
    output cpu_rdata, cpu_rdata_dav, cpu_irq, frame_len, overflow, underrun
  );
endinterface

// File: rtl/tx_ram.sv
// Simple dual-port frame store: synchronous write, registered read that
// returns zero on cycles without a read.
module tx_ram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else      rdata <= re ? mem[raddr] : '0;
  end
endmodule

// File: rtl/move_tx_buffer.sv
// Frame buffer between move generation and the CPU: fill during a search,
// freeze on frame_done, drain by CPU reads, release on cpu_ack.
module move_tx_buffer
  import zezima_pkg::*;
#(
  parameter int DW    = MOVE_DW,
  parameter int DEPTH = MOVE_DEPTH,
  parameter int AW    = MOVE_AW
) (
  input  logic           clk,
  input  logic           rst,
  move_tx_buffer_if.slave bus
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  tx_state_t   state;
  logic [AW:0] wr_cnt, rd_ptr, flen, wr_nxt;
  logic        irq, ovf, unr, dav;
  logic        wr_ok, rd_ok;

  assign wr_ok  = (state == FILL_ST) && bus.in_wr && (wr_cnt != FULL);
  assign rd_ok  = (state == READY_ST) && bus.cpu_rd && (rd_ptr < flen);
  assign wr_nxt = wr_cnt + (AW+1)'(wr_ok);

  tx_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_cnt[AW-1:0]),
    .wdata (bus.in_wdata),
    .re    (rd_ok),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (bus.cpu_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= FILL_ST;
      wr_cnt <= '0;
      rd_ptr <= '0;
      flen   <= '0;
      irq    <= 1'b0;
      ovf    <= 1'b0;
      unr    <= 1'b0;
      dav    <= 1'b0;
    end else begin
      dav <= 1'b0;
      case (state)
        FILL_ST: begin
          if (bus.in_wr && wr_cnt == FULL) ovf <= 1'b1;
          wr_cnt <= wr_nxt;
          // No frame is published yet, so any read finds nothing unread.
          if (bus.cpu_rd) unr <= 1'b1;
          if (bus.frame_done) begin
            flen   <= wr_nxt;
            rd_ptr <= '0;
            irq    <= 1'b1;
            state  <= READY_ST;
          end
        end
        READY_ST: begin
          if (bus.in_wr) ovf <= 1'b1;
          if (bus.cpu_rd) begin
            if (rd_ok) begin
              dav    <= 1'b1;
              rd_ptr <= rd_ptr + 1'b1;
            end else begin
              unr <= 1'b1;
            end
          end
          // Flush wins over the pointer bump; the read already went to the RAM.
          if (bus.cpu_ack) begin
            irq    <= 1'b0;
            wr_cnt <= '0;
            rd_ptr <= '0;
            state  <= FILL_ST;
          end
        end
        default: state <= FILL_ST;
      endcase
    end
  end

  assign bus.cpu_rdata_dav = dav;
  assign bus.cpu_irq       = irq;
  assign bus.frame_len     = flen;
  assign bus.overflow      = ovf;
  assign bus.underrun      = unr;
endmodule

// File: tb/tb_move_tx_buffer.sv
// Directed bench for move_tx_buffer: queue-based frame model checked every
// cycle, plus literal expectations for each scenario.
module tb_move_tx_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  move_tx_buffer_if #(.DW(32), .AW(8)) bus ();

  move_tx_buffer dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Model: the frame is a queue of accepted words, a read index walks it.
  logic [31:0] m_q[$];
  bit          m_ready = 0;
  int          m_rd = 0, m_flen = 0;
  bit          m_ovf = 0, m_unr = 0, m_dav = 0;
  logic [31:0] m_data = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_ready = 0; m_rd = 0; m_flen = 0;
      m_ovf = 0; m_unr = 0; m_dav = 0; m_data = 0;
    end else begin
      m_dav = 0; m_data = 0;
      if (!m_ready) begin
        if (bus.in_wr) begin
          if (m_q.size() < 256) m_q.push_back(bus.in_wdata);
          else m_ovf = 1;
        end
        if (bus.cpu_rd) m_unr = 1;
        if (bus.frame_done) begin
          m_flen = m_q.size(); m_ready = 1; m_rd = 0;
        end
      end else begin
        if (bus.in_wr) m_ovf = 1;
        if (bus.cpu_rd) begin
          if (m_rd < m_flen) begin
            m_dav = 1; m_data = m_q[m_rd]; m_rd++;
          end else m_unr = 1;
        end
        if (bus.cpu_ack) begin
          m_q.delete(); m_ready = 0; m_rd = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("dav",       64'(bus.cpu_rdata_dav), 64'(m_dav));
    chk("rdata",     64'(bus.cpu_rdata),     64'(m_data));
    chk("irq",       64'(bus.cpu_irq),       64'(m_ready));
    chk("frame_len", 64'(bus.frame_len),     64'(m_flen));
    chk("overflow",  64'(bus.overflow),      64'(m_ovf));
    chk("underrun",  64'(bus.underrun),      64'(m_unr));
  end

  logic [31:0] got[$];
  always @(negedge clk) if (bus.cpu_rdata_dav === 1'b1) got.push_back(bus.cpu_rdata);

  task automatic step(input bit wr = 0, input logic [31:0] wd = 0, input bit fd = 0,
                      input bit rd = 0, input bit ack = 0);
    bus.in_wr = wr; bus.in_wdata = wd; bus.frame_done = fd;
    bus.cpu_rd = rd; bus.cpu_ack = ack;
    @(posedge clk); #1;
    bus.in_wr = 0; bus.in_wdata = 0; bus.frame_done = 0; bus.cpu_rd = 0; bus.cpu_ack = 0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 0; step(); step(); rst = 1;
  endtask

  initial begin
    bus.in_wr = 0; bus.in_wdata = 0; bus.frame_done = 0; bus.cpu_rd = 0; bus.cpu_ack = 0;

    // Reset with random activity on every input.
    for (int i = 0; i < 6; i++)
      step(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    settle();
    chk("rst_irq", 64'(bus.cpu_irq), 0);
    chk("rst_len", 64'(bus.frame_len), 0);
    chk("rst_flags", 64'({bus.overflow, bus.underrun, bus.cpu_rdata_dav}), 0);
    rst = 1;
    step(.rd(1)); settle();
    chk("rst_rd_dav", 64'(bus.cpu_rdata_dav), 0);
    chk("rst_rd_underrun", 64'(bus.underrun), 1);
    do_reset();

    // Basic frame.
    step(1, 32'h0000_1234); step(1, 32'h0000_5678); step(1, 32'h0000_9ABC);
    step(.fd(1)); settle();
    chk("basic_irq", 64'(bus.cpu_irq), 1);
    chk("basic_len", 64'(bus.frame_len), 3);
    got.delete();
    step(.rd(1)); step(.rd(1)); step(.rd(1)); settle();
    chk("basic_cnt", 64'(got.size()), 3);
    if (got.size() == 3) begin
      chk("basic_d0", 64'(got[0]), 64'h1234);
      chk("basic_d1", 64'(got[1]), 64'h5678);
      chk("basic_d2", 64'(got[2]), 64'h9ABC);
    end
    step(1, 32'h0000_DEAD); settle();
    chk("ready_wr_ovf", 64'(bus.overflow), 1);
    chk("ready_wr_len", 64'(bus.frame_len), 3);
    step(.ack(1)); settle();
    chk("ack_irq", 64'(bus.cpu_irq), 0);

    // Edge: write accepted right after ack, last write coincident with frame_done.
    step(1, 32'h11); step(1, 32'h22); step(1, 32'h0000_00AA, 1); settle();
    chk("edge_len", 64'(bus.frame_len), 3);
    got.delete();
    for (int i = 0; i < 3; i++) step(.rd(1));
    settle();
    chk("edge_unr_before", 64'(bus.underrun), 0);
    step(.rd(1)); settle();
    chk("edge_4th_dav", 64'(bus.cpu_rdata_dav), 0);
    chk("edge_4th_unr", 64'(bus.underrun), 1);
    chk("edge_cnt", 64'(got.size()), 3);
    if (got.size() == 3) begin
      chk("edge_d0", 64'(got[0]), 64'h11);
      chk("edge_d2", 64'(got[2]), 64'hAA);
    end
    step(.ack(1));

    // Empty frame.
    do_reset();
    step(.fd(1)); settle();
    chk("empty_len", 64'(bus.frame_len), 0);
    chk("empty_irq", 64'(bus.cpu_irq), 1);
    step(.rd(1)); settle();
    chk("empty_dav", 64'(bus.cpu_rdata_dav), 0);
    chk("empty_unr", 64'(bus.underrun), 1);
    step(.ack(1));

    // Capacity: the 257th write is dropped.
    do_reset();
    for (int i = 0; i < 257; i++) step(1, 32'(i));
    step(.fd(1)); settle();
    chk("cap_len", 64'(bus.frame_len), 256);
    chk("cap_ovf", 64'(bus.overflow), 1);
    got.delete();
    for (int i = 0; i < 256; i++) step(.rd(1));
    settle();
    chk("cap_cnt", 64'(got.size()), 256);
    begin
      int bad = 0;
      foreach (got[i]) if (got[i] !== 32'(i)) bad++;
      chk("cap_data_bad", 64'(bad), 0);
    end
    step(.ack(1));

    // Flush: ack together with the first of three reads.
    do_reset();
    step(1, 32'hC1); step(1, 32'hC2); step(1, 32'hC3); step(.fd(1));
    step(1, 32'hBAD); settle();
    chk("iso_ovf", 64'(bus.overflow), 1);
    chk("iso_len", 64'(bus.frame_len), 3);
    got.delete();
    step(.rd(1), .ack(1)); step(.rd(1)); step(.rd(1)); settle();
    chk("flush_cnt", 64'(got.size()), 1);
    if (got.size() == 1) chk("flush_d0", 64'(got[0]), 64'hC1);
    chk("flush_irq", 64'(bus.cpu_irq), 0);

    // Next frame holds only its own words.
    step(1, 32'hD1); step(1, 32'hD2); step(.fd(1)); settle();
    chk("next_len", 64'(bus.frame_len), 2);
    got.delete();
    step(.rd(1)); step(.rd(1)); settle();
    chk("next_cnt", 64'(got.size()), 2);
    if (got.size() == 2) begin
      chk("next_d0", 64'(got[0]), 64'hD1);
      chk("next_d1", 64'(got[1]), 64'hD2);
    end
    step(.ack(1));

    // Reset mid-drain.
    step(1, 32'hE1); step(1, 32'hE2); step(1, 32'hE3); step(.fd(1));
    step(.rd(1));
    rst = 0; settle();
    chk("mid_irq", 64'(bus.cpu_irq), 0);
    chk("mid_len", 64'(bus.frame_len), 0);
    chk("mid_outs", 64'({bus.cpu_rdata, bus.cpu_rdata_dav, bus.overflow, bus.underrun}), 0);
    step(); rst = 1; step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
